// File: rtl/vco_adc_pkg.sv
// ---------------------------------------------------------------------------
// vco_adc_pkg
//   Shared helpers for the VCO-ADC quantizer:
//     - cnt_width()      width of one per-cycle phase-transition count
//     - phase_idx()      base bit of channel k inside the packed phase bus
//     - out_idx()        base bit of channel k inside the packed result bus
//     - min_acc_width()  smallest accumulator that cannot overflow
//   Default parameter values are kept here so the top and bench agree.
// ---------------------------------------------------------------------------
package vco_adc_pkg;

  localparam int DEF_PHASE_WIDTH = 11;
  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_OSR_WIDTH   = 10;
  localparam int DEF_ACC_WIDTH   = 16;

  // A count ranges 0..phase_width, so it needs clog2(phase_width+1) bits.
  function automatic int cnt_width(input int phase_width);
    return $clog2(phase_width + 1);
  endfunction

  function automatic int phase_idx(input int k, input int phase_width);
    return k * phase_width;
  endfunction

  function automatic int out_idx(input int k, input int acc_width);
    return k * acc_width;
  endfunction

  // Up to 2**osr_width counts of at most phase_width each, plus one sign bit
  // so a differential result never wraps.
  function automatic int min_acc_width(input int phase_width, input int osr_width);
    return cnt_width(phase_width) + osr_width + 1;
  endfunction

endpackage

// File: rtl/vco_adc_quant_if.sv
// ---------------------------------------------------------------------------
// vco_adc_quant_if
//   Frame output channel of the VCO-ADC quantizer.
//     dout        packed signed frame results, channel k at [k*ACC_WIDTH +: ACC_WIDTH]
//     dout_valid  a frame is being presented
//     dout_ready  consumer accepts the frame
//     overrun     sticky flag: a completed frame was dropped
//   master = quantizer side, slave = consumer side.
// ---------------------------------------------------------------------------
interface vco_adc_quant_if #(
  parameter int NUM_CH    = 2,
  parameter int ACC_WIDTH = 16
);

  logic [NUM_CH*ACC_WIDTH-1:0] dout;
  logic                        dout_valid;
  logic                        dout_ready;
  logic                        overrun;

  modport master (
    output dout,
    output dout_valid,
    output overrun,
    input  dout_ready
  );

  modport slave (
    input  dout,
    input  dout_valid,
    input  overrun,
    output dout_ready
  );

endinterface

// File: rtl/vco_phase_counter.sv
// ---------------------------------------------------------------------------
// vco_phase_counter
//   One channel of ring-VCO phase-edge counting.
//     clk, rst   system clock, synchronous active-high reset
//     enb        active-low run enable; while high the sample registers hold
//     p          asynchronous VCO phase outputs of this channel
//     cnt        number of phase bits that changed between the last two
//                synchronized samples (combinational from registers)
//   s1/s2 form a 2-flop synchronizer, s3 keeps the previous sample.
// ---------------------------------------------------------------------------
module vco_phase_counter
  import vco_adc_pkg::*;
#(
  parameter  int PHASE_WIDTH = DEF_PHASE_WIDTH,
  localparam int CNT_WIDTH   = cnt_width(PHASE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enb,
  input  logic [PHASE_WIDTH-1:0] p,
  output logic [CNT_WIDTH-1:0]   cnt
);

  logic [PHASE_WIDTH-1:0] s1;
  logic [PHASE_WIDTH-1:0] s2;
  logic [PHASE_WIDTH-1:0] s3;
  logic [PHASE_WIDTH-1:0] edges;

  // NOTE: non-blocking assignments let s1->s2->s3 shift as one register
  // chain; blocking ones would collapse the pipeline into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (!enb) begin
      s1 <= p;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // A changed bit between consecutive samples is one phase transition.
  assign edges = s2 ^ s3;

  // NOTE: cnt gets a value before the loop so every path assigns it and no
  // latch is inferred.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < PHASE_WIDTH; i++) begin
      cnt = cnt + CNT_WIDTH'(edges[i]);
    end
  end

endmodule

// File: rtl/vco_adc_quant.sv
// ---------------------------------------------------------------------------
// vco_adc_quant
//   Multi-channel VCO-ADC digital quantizer: counts ring-VCO phase edges per
//   clock, sums them over N = osr+1 valid counts (sinc1) and hands one frame
//   per channel to the consumer through a valid/ready handshake.
//     clk, rst    system clock, synchronous active-high reset
//     enb         active-low run enable (1 = halt and drop the partial frame)
//     p_in        asynchronous VCO phases, channel k at [k*PHASE_WIDTH +: PHASE_WIDTH]
//     osr         samples per frame minus one, latched at frame start
//     diff_mode   1 = pairwise differential results, sampled at frame end
//     dout_if     frame output channel (dout, dout_valid, dout_ready, overrun)
// ---------------------------------------------------------------------------
module vco_adc_quant
  import vco_adc_pkg::*;
#(
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int OSR_WIDTH   = DEF_OSR_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enb,
  input  logic [NUM_CH*PHASE_WIDTH-1:0] p_in,
  input  logic [OSR_WIDTH-1:0]          osr,
  input  logic                          diff_mode,
  vco_adc_quant_if.master               dout_if
);

  localparam int CNT_WIDTH = cnt_width(PHASE_WIDTH);

  // Parameter sanity checks at elaboration.
  if (ACC_WIDTH < min_acc_width(PHASE_WIDTH, OSR_WIDTH)) begin : g_acc_width_check
    $error("vco_adc_quant: ACC_WIDTH too small for PHASE_WIDTH/OSR_WIDTH");
  end
  if ((NUM_CH % 2) != 0) begin : g_num_ch_check
    $error("vco_adc_quant: NUM_CH must be even");
  end

  // -------------------------------------------------------------------------
  // Per-channel phase-edge counters
  // -------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] cnt [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    vco_phase_counter #(
      .PHASE_WIDTH (PHASE_WIDTH)
    ) u_counter (
      .clk (clk),
      .rst (rst),
      .enb (enb),
      .p   (p_in[phase_idx(k, PHASE_WIDTH) +: PHASE_WIDTH]),
      .cnt (cnt[k])
    );
  end

  // -------------------------------------------------------------------------
  // Priming: the count is meaningful only once s1..s3 have all been loaded
  // since the last enable, i.e. from the 3rd enabled edge on.
  // -------------------------------------------------------------------------
  logic [2:0] prime;
  logic       count_valid;

  always_ff @(posedge clk) begin
    if (rst || enb) begin
      prime <= '0;
    end else begin
      prime <= {prime[1:0], 1'b1};
    end
  end

  assign count_valid = prime[2] && !enb;

  // -------------------------------------------------------------------------
  // Frame accumulation
  // -------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0] acc [NUM_CH];
  logic [ACC_WIDTH-1:0] sum [NUM_CH];
  logic [OSR_WIDTH-1:0] scnt;
  logic [OSR_WIDTH-1:0] n_m1;
  logic [OSR_WIDTH-1:0] frame_n_m1;
  logic                 frame_end;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      sum[k] = acc[k] + ACC_WIDTH'(cnt[k]);
    end
  end

  // The first count of a frame uses osr directly; later counts use the value
  // latched at that first count, so mid-frame osr changes wait a frame.
  assign frame_n_m1 = (scnt == '0) ? osr : n_m1;
  assign frame_end  = count_valid && (scnt == frame_n_m1);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      scnt <= '0;
      n_m1 <= '0;
    end else if (enb) begin
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      scnt <= '0;
    end else if (count_valid) begin
      if (frame_end) begin
        // The final sums go to the output; the next count opens a new frame.
        for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
        scnt <= '0;
      end else begin
        for (int k = 0; k < NUM_CH; k++) acc[k] <= sum[k];
        scnt <= scnt + OSR_WIDTH'(1);
        if (scnt == '0) n_m1 <= osr;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping: plain sums, or acc_2j - acc_2j+1 on the even channel with
  // the odd channel of each pair zeroed.
  // -------------------------------------------------------------------------
  logic [NUM_CH*ACC_WIDTH-1:0] frame_data;

  always_comb begin
    frame_data = '0;
    for (int j = 0; j < NUM_CH / 2; j++) begin
      if (diff_mode) begin
        frame_data[out_idx(2*j, ACC_WIDTH) +: ACC_WIDTH]   = sum[2*j] - sum[2*j+1];
        frame_data[out_idx(2*j+1, ACC_WIDTH) +: ACC_WIDTH] = '0;
      end else begin
        frame_data[out_idx(2*j, ACC_WIDTH) +: ACC_WIDTH]   = sum[2*j];
        frame_data[out_idx(2*j+1, ACC_WIDTH) +: ACC_WIDTH] = sum[2*j+1];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output register and handshake. enb does not touch this stage, so a
  // pending frame survives a halt and can still be accepted.
  // -------------------------------------------------------------------------
  logic [NUM_CH*ACC_WIDTH-1:0] dout_q;
  logic                        dout_valid_q;
  logic                        overrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (frame_end) begin
      if (!dout_valid_q || dout_if.dout_ready) begin
        // Output slot is free or being emptied this cycle: take the new frame.
        dout_q       <= frame_data;
        dout_valid_q <= 1'b1;
      end else begin
        // Consumer stalled: keep the old frame, drop the new one.
        overrun_q <= 1'b1;
      end
    end else if (dout_valid_q && dout_if.dout_ready) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign dout_if.dout       = dout_q;
  assign dout_if.dout_valid = dout_valid_q;
  assign dout_if.overrun    = overrun_q;

endmodule

// File: tb/tb_vco_adc_quant.sv
// ---------------------------------------------------------------------------
// tb_vco_adc_quant
//   Scoreboard bench for vco_adc_quant. The driver applies inputs on the
//   falling edge and advances a reference model that works on the history of
//   enabled p_in samples and frame sums; completed frames that the output
//   stage should accept are queued. One monitor compares every accepted
//   transfer against the queue, another compares dout_valid/overrun each
//   cycle.
// ---------------------------------------------------------------------------
module tb_vco_adc_quant;

  localparam int PW  = 11;
  localparam int NCH = 2;
  localparam int OW  = 10;
  localparam int AW  = 16;

  typedef logic [NCH*AW-1:0] frame_t;
  typedef logic [NCH*PW-1:0] phase_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          enb;
  phase_t        p_in;
  logic [OW-1:0] osr;
  logic          diff_mode;

  always #5 clk = ~clk;

  vco_adc_quant_if #(.NUM_CH(NCH), .ACC_WIDTH(AW)) dif ();

  vco_adc_quant #(
    .PHASE_WIDTH (PW),
    .NUM_CH      (NCH),
    .OSR_WIDTH   (OW),
    .ACC_WIDTH   (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .p_in      (p_in),
    .osr       (osr),
    .diff_mode (diff_mode),
    .dout_if   (dif)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  phase_t hist [$];      // enabled p_in samples, newest first
  int     run;           // enabled edges since last reset/halt (saturates at 3)
  int     fr_cnt;        // counts taken in the current frame
  int     fr_n;          // frame length latched at frame start
  int     fsum [NCH];
  bit     exp_valid;
  bit     exp_ovr;
  frame_t exp_q [$];
  frame_t last_dout;
  int     xfers;

  function automatic frame_t make_frame(input bit d);
    frame_t f;
    f = '0;
    for (int j = 0; j < NCH / 2; j++) begin
      if (d) begin
        f[2*j*AW +: AW]     = AW'(fsum[2*j] - fsum[2*j+1]);
        f[(2*j+1)*AW +: AW] = '0;
      end else begin
        f[2*j*AW +: AW]     = AW'(fsum[2*j]);
        f[(2*j+1)*AW +: AW] = AW'(fsum[2*j+1]);
      end
    end
    return f;
  endfunction

  task automatic clear_frame();
    fr_cnt = 0;
    for (int k = 0; k < NCH; k++) fsum[k] = 0;
  endtask

  // Advances the model across the coming rising edge using current inputs.
  task automatic model_step();
    bit     done;
    bit     xfer;
    frame_t f;
    phase_t x;
    done = 1'b0;
    f    = '0;
    xfer = exp_valid && dif.dout_ready;
    if (rst) begin
      hist.delete();
      repeat (3) hist.push_front('0);
      run       = 0;
      exp_valid = 1'b0;
      exp_ovr   = 1'b0;
      exp_q.delete();
      clear_frame();
      return;
    end
    if (enb) begin
      run = 0;
      clear_frame();
    end else begin
      if (run >= 3) begin
        x = hist[1] ^ hist[2];
        if (fr_cnt == 0) fr_n = int'(osr) + 1;
        for (int k = 0; k < NCH; k++) fsum[k] += $countones(x[k*PW +: PW]);
        fr_cnt++;
        if (fr_cnt == fr_n) begin
          done = 1'b1;
          f    = make_frame(diff_mode);
          clear_frame();
        end
      end
      hist.push_front(p_in);
      void'(hist.pop_back());
      if (run < 3) run++;
    end
    if (done) begin
      if (!exp_valid || dif.dout_ready) begin
        exp_valid = 1'b1;
        exp_q.push_back(f);
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (xfer) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Monitors
  // -------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("dout_valid", dif.dout_valid, exp_valid);
      check("overrun", dif.overrun, exp_ovr);
    end
  end

  initial begin
    frame_t f;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && dif.dout_valid && dif.dout_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL xfer_unexpected: got frame %0h, expected no frame at %0t",
                   dif.dout, $time);
        end else begin
          f = exp_q.pop_front();
          check("dout", dif.dout, f);
        end
        last_dout = dif.dout;
        xfers++;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  localparam phase_t TOG_3_5 = {11'b000_0001_1111, 11'b000_0000_0111};
  localparam phase_t TOG_3_0 = {11'b000_0000_0000, 11'b000_0000_0111};
  localparam phase_t TOG_ALL = {NCH*PW{1'b1}};

  task automatic run_toggle(input int n, input phase_t mask);
    for (int i = 0; i < n; i++) begin
      p_in = p_in ^ mask;
      tick();
    end
  endtask

  initial begin
    xfers          = 0;
    last_dout      = '0;
    rst            = 1'b1;
    enb            = 1'b1;
    p_in           = '0;
    osr            = 10'd3;
    diff_mode      = 1'b0;
    dif.dout_ready = 1'b1;
    tick();
    tick();
    check("reset_dout", dif.dout, 0);
    check("reset_valid", dif.dout_valid, 0);
    check("reset_overrun", dif.overrun, 0);
    rst = 1'b0;
    tick();

    // Static phases: all-zero frames every 4 cycles.
    enb  = 1'b0;
    p_in = phase_t'($urandom);
    run_toggle(20, '0);
    check("static_dout", last_dout, 0);

    // 3 and 5 toggling bits, N = 8.
    osr = 10'd7;
    run_toggle(40, TOG_3_5);
    check("toggle_dout", last_dout, 32'h0028_0018);

    // Same stimulus, differential.
    diff_mode = 1'b1;
    run_toggle(40, TOG_3_5);
    check("diff_dout", last_dout, 32'h0000_fff0);
    diff_mode = 1'b0;

    // Stalled consumer across two frame completions, then release.
    dif.dout_ready = 1'b0;
    run_toggle(20, TOG_3_5);
    check("stall_overrun", dif.overrun, 1);
    dif.dout_ready = 1'b1;
    run_toggle(20, TOG_3_5);
    check("post_stall_dout", last_dout, 32'h0028_0018);

    // Halt mid-frame for two cycles; next frame after priming + 8 counts.
    run_toggle(3, TOG_3_0);
    enb = 1'b1;
    run_toggle(2, TOG_3_0);
    enb = 1'b0;
    run_toggle(14, TOG_3_0);
    check("reenable_dout", last_dout, 32'h0000_0018);

    // Reset while a frame is pending and overrun is set.
    dif.dout_ready = 1'b0;
    run_toggle(20, TOG_3_5);
    rst = 1'b1;
    tick();
    check("midrst_dout", dif.dout, 0);
    check("midrst_valid", dif.dout_valid, 0);
    check("midrst_overrun", dif.overrun, 0);
    rst            = 1'b0;
    dif.dout_ready = 1'b1;
    run_toggle(30, TOG_3_5);

    // Randomized traffic: short frames, osr changes, stalls, halts, resets.
    for (int i = 0; i < 2500; i++) begin
      p_in = p_in ^ phase_t'($urandom);
      if ($urandom_range(0, 9) == 0) osr = OW'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) diff_mode = ~diff_mode;
      dif.dout_ready = ($urandom_range(0, 3) != 0);
      enb = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst            = 1'b0;
    enb            = 1'b0;
    diff_mode      = 1'b0;
    dif.dout_ready = 1'b1;

    // Largest frame with every phase bit toggling every cycle.
    osr = 10'd1023;
    run_toggle(2 * 1024 + 20, TOG_ALL);
    check("max_dout", last_dout, 32'h2c00_2c00);

    // Drain.
    enb = 1'b1;
    repeat (5) tick();
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
